// File: rtl/act_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : act_mem_if
// Description : Start/status, memory read port and output stream signals
//               of the activation memory reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface act_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              start;
    logic [2:0]        step_idx;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport slave (
        input  start, step_idx, mem_dout, out_ready,
        output busy, done, err, mem_addr, mem_rd, out_data, out_valid, out_last
    );

    modport master (
        output start, step_idx, mem_dout, out_ready,
        input  busy, done, err, mem_addr, mem_rd, out_data, out_valid, out_last
    );
endinterface
`default_nettype wire

// File: rtl/act_mem_reader.sv
`default_nettype none
// ============================================================================
// Module      : act_mem_reader
// Description : Streams all activations of one timestep from the activation
//               memory through a 2-entry skid FIFO to a valid/ready consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module act_mem_reader #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int N_UNITS = 53,
    parameter int N_STEPS = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    act_mem_if.slave  bus
);
    localparam int CNT_W = $clog2(N_UNITS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic              r_inflight;
    logic              r_infl_last;
    logic [DATA_W-1:0] r_fifo_data [2];
    logic              r_fifo_last [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;
    logic              r_done;
    logic              r_err;

    logic w_start_ok;
    logic w_step_ok;
    logic w_valid;
    logic w_pop;
    logic w_head_last;
    logic w_rd_last;
    logic w_issue;

    // A start coinciding with the done pulse is still treated as busy
    assign w_start_ok  = bus.start && (r_state == S_IDLE) && !r_done;
    assign w_step_ok   = 32'(bus.step_idx) < N_STEPS;
    assign w_valid     = (r_count != 2'd0);
    assign w_pop       = w_valid && bus.out_ready;
    assign w_head_last = r_fifo_last[r_rptr];
    assign w_rd_last   = (r_rd_cnt == CNT_W'(N_UNITS - 1));
    // Issue only when the read is guaranteed a FIFO slot on arrival
    assign w_issue     = (r_state == S_RUN) &&
                         (({1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop}) < 3'd2);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok && w_step_ok)  w_state_nx = S_RUN;
            S_RUN:   if (w_issue && w_rd_last)     w_state_nx = S_DRAIN;
            S_DRAIN: if (w_pop && w_head_last)     w_state_nx = S_IDLE;
            default:                               w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_rd_cnt    <= '0;
            r_inflight  <= 1'b0;
            r_infl_last <= 1'b0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_last[i] <= 1'b0;
            end
        end else begin
            r_state     <= w_state_nx;
            r_done      <= (r_state == S_DRAIN) && w_pop && w_head_last;
            r_err       <= w_start_ok && !w_step_ok;
            r_inflight  <= w_issue;
            r_infl_last <= w_issue && w_rd_last;

            if (w_start_ok && w_step_ok) begin
                r_base   <= ADDR_W'(32'(bus.step_idx) * N_UNITS);
                r_rd_cnt <= '0;
            end else if (w_issue) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end

            if (r_inflight) begin
                r_fifo_data[r_wptr] <= bus.mem_dout;
                r_fifo_last[r_wptr] <= r_infl_last;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(r_inflight && !w_pop && (r_count == 2'd2)));

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.mem_addr  = (r_state == S_RUN) ? (r_base + ADDR_W'(r_rd_cnt)) : '0;
    assign bus.mem_rd    = w_issue;
    assign bus.out_data  = r_fifo_data[r_rptr];
    assign bus.out_valid = w_valid;
    assign bus.out_last  = w_valid && w_head_last;
endmodule
`default_nettype wire
